// File: rtl/uncached_write_drain_if.sv
// AXI4 write-channel bundle (AW, W, B) between the uncached store drain
// and the write-channel arbiter. The master modport is the drain side.
interface uncached_write_drain_if #(
    parameter int ID_W = 4
);
    // Write address channel
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    // Write data channel
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    // Write response channel
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/uncached_write_drain.sv
// Read side of the uncached-store FIFO. Pops one buffered store at a time
// and issues it as a single-beat AXI4 write (AW + W, then wait for B).
// Only one write is ever outstanding; busy lets the LSU hold uncached
// loads and fences until every buffered store has been acknowledged.
module uncached_write_drain #(
    parameter int ID_W     = 4,
    parameter int AWID_VAL = 1
) (
    input  logic        clk,
    input  logic        rst,

    // Head of the uncached store FIFO (combinational, valid while !fifo_empty)
    input  logic        fifo_empty,
    input  logic [2:0]  fifo_size,
    input  logic [31:0] fifo_addr,
    input  logic [31:0] fifo_data,
    input  logic [3:0]  fifo_dwen,
    output logic        fifo_read_en,

    // AXI4 write channels
    uncached_write_drain_if.master axi,

    // Status
    output logic        busy,
    output logic        wr_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] WAIT_B = 2'd2;

    localparam logic [ID_W-1:0] AWID_CONST = AWID_VAL[ID_W-1:0];

    logic [1:0]  state_reg,   state_next;
    logic        aw_done_reg, aw_done_next;
    logic        w_done_reg,  w_done_next;
    logic        wr_err_reg,  wr_err_next;
    logic [31:0] addr_reg;
    logic [2:0]  size_reg;
    logic [31:0] data_reg;
    logic [3:0]  strb_reg;

    logic        in_idle;
    logic        in_send;
    logic        in_wait_b;
    logic        aw_fire;
    logic        w_fire;
    logic        aw_done_now;
    logic        w_done_now;

    assign in_idle   = (state_reg == IDLE);
    assign in_send   = (state_reg == SEND);
    assign in_wait_b = (state_reg == WAIT_B);

    // Pop exactly once per entry: only in IDLE, and never while in reset
    // (the FIFO is being cleared by the same rst).
    assign fifo_read_en = !rst && in_idle && !fifo_empty;

    // Each channel drops its valid once its own handshake has happened.
    assign axi.awvalid = in_send && !aw_done_reg;
    assign axi.wvalid  = in_send && !w_done_reg;
    assign axi.bready  = in_wait_b;

    assign aw_fire     = axi.awvalid && axi.awready;
    assign w_fire      = axi.wvalid  && axi.wready;
    assign aw_done_now = aw_done_reg || aw_fire;
    assign w_done_now  = w_done_reg  || w_fire;

    // Payload comes from the latched entry so it stays stable until accepted.
    assign axi.awid    = AWID_CONST;
    assign axi.awaddr  = addr_reg;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = size_reg;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.wdata   = data_reg;
    assign axi.wstrb   = strb_reg;
    assign axi.wlast   = 1'b1;

    assign busy   = !in_idle || !fifo_empty;
    assign wr_err = wr_err_reg;

    // Next-state logic for the drain sequencer and its completion flags.
    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        wr_err_next  = wr_err_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                // AW and W may complete in either order or together.
                if (aw_done_now && w_done_now) begin
                    state_next   = WAIT_B;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    aw_done_next = aw_done_now;
                    w_done_next  = w_done_now;
                end
            end
            WAIT_B: begin
                if (axi.bvalid) begin
                    // EXOKAY is not expected for a non-exclusive write, so any
                    // non-OKAY response is treated as an error.
                    if (axi.bresp != 2'b00) begin
                        wr_err_next = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                aw_done_next = 1'b0;
                w_done_next  = 1'b0;
            end
        endcase
    end

    // Sequencer state, completion flags and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            wr_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            wr_err_reg  <= wr_err_next;
        end
    end

    // Capture address and size of the head entry as it is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg <= 32'd0;
            size_reg <= 3'd0;
        end else if (fifo_read_en) begin
            addr_reg <= fifo_addr;
            size_reg <= fifo_size;
        end
    end

    // Capture write data and strobes one byte lane at a time.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Byte lane gi of the latched store data and its strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi*8 +: 8] <= 8'd0;
                    strb_reg[gi]        <= 1'b0;
                end else if (fifo_read_en) begin
                    data_reg[gi*8 +: 8] <= fifo_data[gi*8 +: 8];
                    strb_reg[gi]        <= fifo_dwen[gi];
                end
            end
        end
    endgenerate

endmodule
